// File: rtl/imm_decode_stage_pkg.sv
// Shared RV32I definitions: base opcodes and the instruction-format encoding
// used by the decode stage and its immediate generator.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-to-execute bus of the immediate-decode stage. With IMM_RAW12_EN defined
// the raw 12-bit I/S immediate is carried as well.
interface imm_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) ();

  // valid/ready: a beat transfers on a rising edge where valid && ready are both 1;
  // once valid is raised the payload holds until ready is seen; flush overrides all.
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_inst;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
`ifdef IMM_RAW12_EN
  logic [11:0]     out_imm12;
`endif

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_imm, out_fmt, out_illegal
`ifdef IMM_RAW12_EN
    , input out_imm12
`endif
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_imm, out_fmt, out_illegal
`ifdef IMM_RAW12_EN
    , output out_imm12
`endif
  );

endinterface

// File: rtl/imm_decode_stage_imm_gen.sv
// Combinational RV32I format classifier and sign-extended immediate builder.
// With IMM_RAW12_EN defined it also emits the raw 12-bit I/S immediate.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] inst,
  output fmt_e        fmt,
  output logic [31:0] imm,
`ifdef IMM_RAW12_EN
  output logic [11:0] imm12,
`endif
  output logic        illegal
);

  logic [6:0] opc;
  assign opc = inst[6:0];

  always_comb begin
    fmt     = FMT_R;
    imm     = 32'd0;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_FENCE, OPC_SYSTEM: begin
        fmt = FMT_I;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = {inst[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_OP: fmt = FMT_R;
      default: illegal = 1'b1;
    endcase
  end

`ifdef IMM_RAW12_EN
  always_comb begin
    imm12 = 12'd0;
    if (fmt == FMT_I)      imm12 = inst[31:20];
    else if (fmt == FMT_S) imm12 = {inst[31:25], inst[11:7]};
  end
`endif

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: one output register behind a valid/ready
// handshake with flush. Optional IMM_RAW12_EN adds the registered out_imm12.
module imm_decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input logic clk,
  input logic rst,
  imm_decode_stage_if.slave bus
);

  fmt_e        dec_fmt;
  logic [31:0] dec_imm;
  logic        dec_illegal;
`ifdef IMM_RAW12_EN
  logic [11:0] dec_imm12;
  logic [11:0] imm12_q;
`endif

  imm_gen u_imm_gen (
    .inst    (bus.in_inst),
    .fmt     (dec_fmt),
    .imm     (dec_imm),
`ifdef IMM_RAW12_EN
    .imm12   (dec_imm12),
`endif
    .illegal (dec_illegal)
  );

  logic            valid_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      fmt_q;
  logic            illegal_q;
  logic            load;

  // The register frees up in the same cycle execute drains it.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      imm_q     <= '0;
      fmt_q     <= '0;
      illegal_q <= 1'b0;
`ifdef IMM_RAW12_EN
      imm12_q   <= '0;
`endif
    end else begin
      if (bus.flush)          valid_q <= 1'b0;
      else if (load)          valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;

      if (load) begin
        pc_q      <= bus.in_pc;
        inst_q    <= bus.in_inst;
        imm_q     <= dec_imm;
        fmt_q     <= dec_fmt;
        illegal_q <= dec_illegal;
`ifdef IMM_RAW12_EN
        imm12_q   <= dec_imm12;
`endif
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_inst    = inst_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_fmt     = fmt_q;
  assign bus.out_illegal = illegal_q;
`ifdef IMM_RAW12_EN
  assign bus.out_imm12   = imm12_q;
`endif

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed scenarios plus random traffic, with a
// negedge monitor comparing against an expected queue fed by a reference decoder.
`timescale 1ns/1ps
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

  imm_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [11:0] imm12;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   model_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference decoder built from the format rules with signed arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    int s;
    s = $signed(inst);
    e.pc = pc; e.inst = inst; e.imm = 0; e.fmt = 0; e.ill = 0; e.imm12 = 0;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F, 7'h73: begin
        e.fmt = 1; e.imm = 32'(s >>> 20); e.imm12 = 12'(inst >> 20);
      end
      7'h23: begin
        e.fmt = 2;
        e.imm = 32'(((s >>> 25) <<< 5) | int'(inst[11:7]));
        e.imm12 = 12'(((inst >> 20) & 32'hFE0) | 32'(inst[11:7]));
      end
      7'h63: begin
        e.fmt = 3;
        e.imm = 32'(((s >>> 31) <<< 12) | (int'(inst[7]) << 11) |
                    (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1));
      end
      7'h37, 7'h17: begin e.fmt = 4; e.imm = inst & 32'hFFFFF000; end
      7'h6F: begin
        e.fmt = 5;
        e.imm = 32'(((s >>> 31) <<< 20) | (int'(inst[19:12]) << 12) |
                    (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1));
      end
      7'h33: e.fmt = 0;
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Monitor: checks what the DUT presents, then advances the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("mon_out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      check("mon_in_ready", 32'(bus.in_ready), 32'((exp_q.size() == 0) || bus.out_ready));
      if (exp_q.size() != 0 && bus.out_valid) begin
        check("mon_pc", bus.out_pc, exp_q[0].pc);
        check("mon_inst", bus.out_inst, exp_q[0].inst);
        check("mon_imm", bus.out_imm, exp_q[0].imm);
        check("mon_fmt", 32'(bus.out_fmt), 32'(exp_q[0].fmt));
        check("mon_illegal", 32'(bus.out_illegal), 32'(exp_q[0].ill));
`ifdef IMM_RAW12_EN
        check("mon_imm12", 32'(bus.out_imm12), 32'(exp_q[0].imm12));
`endif
      end
      model_ready = (exp_q.size() == 0) || bus.out_ready;
      if (bus.flush) begin
        exp_q.delete();
      end else if (bus.in_valid && model_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(ref_decode(bus.in_inst, bus.in_pc));
      end else if (exp_q.size() != 0 && bus.out_ready) begin
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  task automatic check_out(input string name, input logic [31:0] inst,
                           input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_inst"}, bus.out_inst, inst);
    check({name, "_imm"}, bus.out_imm, imm);
    check({name, "_fmt"}, 32'(bus.out_fmt), 32'(fmt));
    check({name, "_illegal"}, 32'(bus.out_illegal), 32'(ill));
  endtask

  logic [6:0]  opc_tab [12] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                                7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
  logic [31:0] rnd;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(0, 0, 0);
    bus.flush = 0;
    bus.out_ready = 1;
    #1 rst = 1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_imm", bus.out_imm, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_inst", bus.out_inst, 0);
    check("rst_out_fmt", 32'(bus.out_fmt), 0);
    check("rst_out_illegal", 32'(bus.out_illegal), 0);
    repeat (2) step();
    rst = 0;

    drive(1, 32'hAAA00013, 32'h100);
    step();
    check_out("addi", 32'hAAA00013, 32'hFFFFFAAA, 3'd1, 1'b0);
`ifdef IMM_RAW12_EN
    check("addi_imm12", 32'(bus.out_imm12), 32'hAAA);
`endif

    drive(1, 32'h0020A423, 32'h104);
    step();
    check_out("sw", 32'h0020A423, 32'h00000008, 3'd2, 1'b0);
    check("sw_in_ready", 32'(bus.in_ready), 1);
    drive(1, 32'hFE000EE3, 32'h108);
    step();
    check_out("beq", 32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
    check("beq_in_ready", 32'(bus.in_ready), 1);
    drive(1, 32'h123452B7, 32'h10C);
    step();
    check_out("lui", 32'h123452B7, 32'h12345000, 3'd4, 1'b0);
    drive(0, 0, 0);
    step();

    drive(1, 32'h0AA0006F, 32'h200);
    step();
    check_out("jal", 32'h0AA0006F, 32'h000000AA, 3'd5, 1'b0);
    bus.out_ready = 0;
    drive(1, 32'hAAA00013, 32'h204);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_inst", bus.out_inst, 32'h0AA0006F);
      check("bp_hold_valid", 32'(bus.out_valid), 1);
      check("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1;
    step();
    check_out("bp_release", 32'hAAA00013, 32'hFFFFFAAA, 3'd1, 1'b0);
    check("bp_release_pc", bus.out_pc, 32'h204);
    drive(0, 0, 0);
    step();
    check("bp_drain_valid", 32'(bus.out_valid), 0);

    bus.out_ready = 0;
    drive(1, 32'h0020A423, 32'h300);
    step();
    bus.flush = 1;
    drive(1, 32'hAAA00013, 32'h304);
    step();
    check("flush_valid", 32'(bus.out_valid), 0);
    check("flush_in_ready", 32'(bus.in_ready), 1);
    bus.flush = 0;
    bus.out_ready = 1;
    drive(0, 0, 0);
    step();

    drive(1, 32'h0000007F, 32'h400);
    step();
    check_out("illegal", 32'h0000007F, 32'h0, 3'd0, 1'b1);
    drive(1, 32'hAAA00013, 32'h404);
    step();
    drive(0, 0, 0);
    #2 rst = 1;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 0);
    check("rst_mid_imm", bus.out_imm, 0);
    check("rst_mid_inst", bus.out_inst, 0);
    check("rst_mid_pc", bus.out_pc, 0);
    step();
    rst = 0;
    drive(1, 32'h0020A423, 32'h500);
    step();
    check_out("post_rst", 32'h0020A423, 32'h00000008, 3'd2, 1'b0);
    drive(0, 0, 0);
    step();

    for (int i = 0; i < 400; i++) begin
      rnd = $urandom();
      drive($urandom_range(0, 3) != 0, {rnd[31:7], opc_tab[$urandom_range(0, 11)]}, $urandom());
      bus.out_ready = $urandom_range(0, 3) != 0;
      bus.flush = $urandom_range(0, 15) == 0;
      step();
    end
    drive(0, 0, 0);
    bus.flush = 0;
    bus.out_ready = 1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
